// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline around the 32-bit ALU: an operand register stage
// feeding the ALU, then a result stage with sticky flags and an op counter.
module alu_exec_stage #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [2:0]      in_cmd,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic            out_carry,
  output logic            out_overflow,
  output logic            out_zero,
  output logic [TAGW-1:0] out_tag,
  input  logic            clear_sticky,
  output logic            sticky_carry,
  output logic            sticky_overflow,
  output logic [15:0]     op_count
);

  localparam logic [2:0] CmdAdd = 3'd0;
  localparam logic [2:0] CmdSub = 3'd1;

  logic            s1Valid;
  logic [31:0]     s1A;
  logic [31:0]     s1B;
  logic [2:0]      s1Cmd;
  logic [TAGW-1:0] s1Tag;
  logic            s2Valid;
  logic            s1Adv;
  logic            s2Adv;

  logic [31:0] aluResult;
  logic        aluCarry;
  logic        aluOverflow;
  logic        aluZero;
  logic        isArith;
  logic        maskCarry;
  logic        maskOverflow;

  ALU alu (
    .a        (s1A),
    .b        (s1B),
    .cmd      (s1Cmd),
    .result   (aluResult),
    .carryout (aluCarry),
    .overflow (aluOverflow),
    .zero     (aluZero)
  );

  always_comb begin
    s2Adv        = !s2Valid || out_ready;
    s1Adv        = !s1Valid || s2Adv;
    in_ready     = s1Adv;
    out_valid    = s2Valid;
    isArith      = (s1Cmd == CmdAdd) || (s1Cmd == CmdSub);
    maskCarry    = aluCarry & isArith;
    maskOverflow = aluOverflow & isArith;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid         <= 1'b0;
      s1A             <= '0;
      s1B             <= '0;
      s1Cmd           <= '0;
      s1Tag           <= '0;
      s2Valid         <= 1'b0;
      out_result      <= '0;
      out_carry       <= 1'b0;
      out_overflow    <= 1'b0;
      out_zero        <= 1'b0;
      out_tag         <= '0;
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
      op_count        <= '0;
    end else begin
      if (s1Adv) begin
        s1Valid <= in_valid;
        s1A     <= in_a;
        s1B     <= in_b;
        s1Cmd   <= in_cmd;
        s1Tag   <= in_tag;
      end
      if (s2Adv) begin
        s2Valid      <= s1Valid;
        out_result   <= aluResult;
        out_carry    <= maskCarry;
        out_overflow <= maskOverflow;
        out_zero     <= aluZero;
        out_tag      <= s1Tag;
      end
      // Clear takes priority over a same-cycle capture that would set a flag.
      if (clear_sticky) begin
        sticky_carry    <= 1'b0;
        sticky_overflow <= 1'b0;
      end else if (s2Adv && s1Valid) begin
        sticky_carry    <= sticky_carry | maskCarry;
        sticky_overflow <= sticky_overflow | maskOverflow;
      end
      if (s2Valid && out_ready) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// Combinational 32-bit ALU: ADD, SUB, XOR, SLT, AND, NAND, NOR, OR.
module ALU (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  cmd,
  output logic [31:0] result,
  output logic        carryout,
  output logic        overflow,
  output logic        zero
);

  logic [32:0] addSum;
  logic [32:0] subSum;
  logic        addOvf;
  logic        subOvf;
  logic        lessThan;

  always_comb begin
    addSum   = {1'b0, a} + {1'b0, b};
    subSum   = {1'b0, a} + {1'b0, ~b} + 33'd1;
    addOvf   = (a[31] == b[31]) && (addSum[31] != a[31]);
    subOvf   = (a[31] != b[31]) && (subSum[31] != a[31]);
    lessThan = $signed(a) < $signed(b);
    result   = '0;
    carryout = 1'b0;
    overflow = 1'b0;
    case (cmd)
      3'd0: begin result = addSum[31:0]; carryout = addSum[32]; overflow = addOvf; end
      3'd1: begin result = subSum[31:0]; carryout = subSum[32]; overflow = subOvf; end
      3'd2: result = a ^ b;
      3'd3: result = {31'd0, lessThan};
      3'd4: result = a & b;
      3'd5: result = ~(a & b);
      3'd6: result = ~(a | b);
      default: result = a | b;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: vector table plus scoreboard queue.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_cmd;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_overflow;
  logic        out_zero;
  logic [3:0]  out_tag;
  logic        clear_sticky;
  logic        sticky_carry;
  logic        sticky_overflow;
  logic [15:0] op_count;

  alu_exec_stage #(.TAGW(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_cmd          (in_cmd),
    .in_tag          (in_tag),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_carry       (out_carry),
    .out_overflow    (out_overflow),
    .out_zero        (out_zero),
    .out_tag         (out_tag),
    .clear_sticky    (clear_sticky),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow),
    .op_count        (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        c;
    logic        o;
  } vec_t;

  exp_t sb[$];
  int   nVec = 0;
  int   nMis = 0;
  int   run = 0;
  int   maxRun = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every handshaken output must match the oldest request.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) run++;
      else run = 0;
      if (run > maxRun) maxRun = run;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("carry", {31'd0, out_carry}, {31'd0, e.c});
          chk("overflow", {31'd0, out_overflow}, {31'd0, e.o});
          chk("zero", {31'd0, out_zero}, {31'd0, (e.res == 32'd0)});
          chk("tag", {28'd0, out_tag}, {28'd0, e.tag});
        end
      end
    end
  end

  function automatic exp_t refAlu(input logic [2:0] c, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] t);
    exp_t   e;
    longint sa;
    longint sbv;
    longint s;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.tag = t;
    e.c   = 1'b0;
    e.o   = 1'b0;
    case (c)
      3'd0: begin
        e.res = a + b;
        e.c   = (longint'(a) + longint'(b)) > 64'sd4294967295;
        s     = sa + sbv;
        e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = sa - sbv;
        e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: e.res = a ^ b;
      3'd3: e.res = (sa < sbv) ? 32'd1 : 32'd0;
      3'd4: e.res = a & b;
      3'd5: e.res = ~(a & b);
      3'd6: e.res = ~(a | b);
      default: e.res = a | b;
    endcase
    return e;
  endfunction

  task automatic tryIssue(input exp_t e, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, output logic acc);
    in_valid = 1'b1;
    in_cmd   = c;
    in_a     = a;
    in_b     = b;
    in_tag   = e.tag;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    if (acc) sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic issue(input exp_t e, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) tryIssue(e, c, a, b, acc);
    if (!acc) chk("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
  endtask

  vec_t vecs[12];
  exp_t e;
  logic acc;
  logic expSC;
  logic expSO;
  int   accepted;
  int   stale;

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 4'd3,  32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'd4,  32'h80000000, 1'b0, 1'b1};
    vecs[2]  = '{3'd2, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'd5,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 32'hFFFFFFFB, 32'h00000003, 4'd6,  32'h00000001, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 32'h00000003, 32'hFFFFFFFB, 4'd7,  32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 32'h12345678, 32'h0F0F0F0F, 4'd8,  32'h02040608, 1'b0, 1'b0};
    vecs[6]  = '{3'd5, 32'h12345678, 32'h0F0F0F0F, 4'd9,  32'hFDFBF9F7, 1'b0, 1'b0};
    vecs[7]  = '{3'd6, 32'h12345678, 32'h0F0F0F0F, 4'd10, 32'hE0C0A080, 1'b0, 1'b0};
    vecs[8]  = '{3'd7, 32'h12345678, 32'h0F0F0F0F, 4'd11, 32'h1F3F5F7F, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 32'h00000005, 32'h00000005, 4'd12, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 4'd13, 32'h80000000, 1'b0, 1'b1};
    vecs[11] = '{3'd1, 32'h00000000, 32'h00000001, 4'd14, 32'hFFFFFFFF, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cmd = '0; in_tag = '0;
    out_ready = 1'b1; clear_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_flags", {28'd0, out_carry, out_overflow, sticky_carry, sticky_overflow}, 32'd0);
    @(posedge clk);
    #1;

    // Table vectors one at a time, tracking expected sticky accumulation.
    expSC = 1'b0; expSO = 1'b0;
    foreach (vecs[i]) begin
      e = '{vecs[i].res, vecs[i].c, vecs[i].o, vecs[i].tag};
      issue(e, vecs[i].cmd, vecs[i].a, vecs[i].b);
      drain();
      expSC |= vecs[i].c;
      expSO |= vecs[i].o;
      chk("sticky_carry", {31'd0, sticky_carry}, {31'd0, expSC});
      chk("sticky_overflow", {31'd0, sticky_overflow}, {31'd0, expSO});
    end

    // Backpressure: only two ops fit while the consumer stalls.
    doReset();
    out_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 4; k++) begin
      e = refAlu(3'd0, 32'd100 + accepted, 32'd7, 4'(accepted + 1));
      tryIssue(e, 3'd0, 32'd100 + accepted, 32'd7, acc);
      if (acc) accepted++;
    end
    chk("bp_accepted", accepted, 32'd2);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_tag", {28'd0, out_tag}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      e = refAlu(3'd0, 32'd100 + k, 32'd7, 4'(k + 1));
      issue(e, 3'd0, 32'd100 + k, 32'd7);
    end
    drain();
    chk("bp_op_count", {16'd0, op_count}, 32'd4);

    // Full-rate random stream.
    maxRun = 0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      e = refAlu(c, a, b, 4'($urandom_range(0, 15)));
      issue(e, c, a, b);
    end
    drain();
    chk("stream_run", maxRun, 32'd8);
    clear_sticky = 1'b1;
    @(posedge clk);
    #1;
    clear_sticky = 1'b0;
    @(negedge clk);
    chk("clear_sc", {31'd0, sticky_carry}, 32'd0);
    chk("clear_so", {31'd0, sticky_overflow}, 32'd0);

    // Clear in the same cycle as a carry-setting capture: clear wins.
    @(posedge clk);
    #1;
    e = '{32'h0, 1'b1, 1'b0, 4'd2};
    issue(e, 3'd0, 32'hFFFFFFFF, 32'h1);
    clear_sticky = 1'b1;
    @(posedge clk);
    #1;
    clear_sticky = 1'b0;
    @(negedge clk);
    chk("clearwin_valid", {31'd0, out_valid}, 32'd1);
    chk("clearwin_sc", {31'd0, sticky_carry}, 32'd0);
    drain();

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = refAlu(3'd2, 32'hA5A5A5A5, 32'(k), 4'(k + 9));
      tryIssue(e, 3'd2, 32'hA5A5A5A5, 32'(k), acc);
    end
    chk("full_sb", sb.size(), 32'd2);
    doReset();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("stale_outputs", stale, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
